// File: rtl/baccarat_pkg.sv
// Shared types and card helpers for the baccarat round controller.
// Provides the sequencer state encoding and raw-card to point-value mapping.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_EVAL,
    S_P3,
    S_BANK,
    S_D3,
    S_RESULT
  } state_t;

  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam logic [3:0] CARD_TEN   = 4'd10;

  // Tens, face cards and the unused codes 14-15 all count as zero points.
  function automatic logic [3:0] card_value(input logic [3:0] card);
    return (card >= CARD_TEN) ? CARD_EMPTY : card;
  endfunction

endpackage

// File: rtl/deal_sequencer_if.sv
// Round-control bundle between the sequencer (master) and the datapath/scorehand side (slave).
// Carries the go request, hand scores, the raw third player card, load strobes, lights and busy.
interface deal_sequencer_if;

  logic       go;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       busy;

  modport master (
    input  go, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, busy
  );

  modport slave (
    output go, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, busy
  );

endinterface

// File: rtl/banker_rule.sv
// Combinational banker third-card table: decides whether the dealer draws
// given the dealer's two-card score and the player's raw third card.
module banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    draw = 1'b0;
    v    = card_value(pcard3);
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat round controller: deals four cards, applies third-card rules and holds the result.
// Optional macro ROUND_COUNT_EN adds saturating rounds/ties counters.
module deal_sequencer
  import baccarat_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned HOLD_W      = $clog2(HOLD_CYCLES + 1)
) (
  input  logic             slow_clock,
  input  logic             resetb,
  deal_sequencer_if.master bus
`ifdef ROUND_COUNT_EN
  ,
  output logic [7:0]       rounds,
  output logic [7:0]       ties
`endif
);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] holdCount_q, holdCount_d;
  logic              playerWin_q, playerWin_d;
  logic              dealerWin_q, dealerWin_d;
  logic              bankerDraw;
  logic              isNatural;
  logic              enterResult;

  banker_rule u_banker_rule (
    .dscore (bus.dscore),
    .pcard3 (bus.pcard3),
    .draw   (bankerDraw)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      holdCount_q <= '0;
      playerWin_q <= 1'b0;
      dealerWin_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      holdCount_q <= holdCount_d;
      playerWin_q <= playerWin_d;
      dealerWin_q <= dealerWin_d;
    end
  end

  // Out-of-range scores (10-15) also satisfy >=8 and so end the round as a natural.
  always_comb begin
    state_d     = state_q;
    holdCount_d = holdCount_q;
    playerWin_d = playerWin_q;
    dealerWin_d = dealerWin_q;
    isNatural   = (bus.pscore >= 4'd8) || (bus.dscore >= 4'd8);
    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d     = S_P1;
          playerWin_d = 1'b0;
          dealerWin_d = 1'b0;
        end
      end
      S_P1: state_d = S_D1;
      S_D1: state_d = S_P2;
      S_P2: state_d = S_D2;
      S_D2: state_d = S_EVAL;
      S_EVAL: begin
        if (isNatural)                 state_d = S_RESULT;
        else if (bus.pscore <= 4'd5)   state_d = S_P3;
        else if (bus.dscore <= 4'd5)   state_d = S_D3;
        else                           state_d = S_RESULT;
      end
      S_P3:   state_d = S_BANK;
      S_BANK: state_d = bankerDraw ? S_D3 : S_RESULT;
      S_D3:   state_d = S_RESULT;
      S_RESULT: begin
        if (holdCount_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d     = S_IDLE;
          holdCount_d = '0;
        end else begin
          holdCount_d = holdCount_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Lights and the hold counter are captured on the edge that enters the result state.
    enterResult = (state_d == S_RESULT) && (state_q != S_RESULT);
    if (enterResult) begin
      playerWin_d = (bus.pscore >= bus.dscore);
      dealerWin_d = (bus.dscore >= bus.pscore);
      holdCount_d = '0;
    end
  end

  assign bus.load_pcard1      = (state_q == S_P1);
  assign bus.load_dcard1      = (state_q == S_D1);
  assign bus.load_pcard2      = (state_q == S_P2);
  assign bus.load_dcard2      = (state_q == S_D2);
  assign bus.load_pcard3      = (state_q == S_P3);
  assign bus.load_dcard3      = (state_q == S_D3);
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.player_win_light = playerWin_q;
  assign bus.dealer_win_light = dealerWin_q;

`ifdef ROUND_COUNT_EN
  logic [7:0] rounds_q, rounds_d;
  logic [7:0] ties_q, ties_d;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      rounds_q <= '0;
      ties_q   <= '0;
    end else begin
      rounds_q <= rounds_d;
      ties_q   <= ties_d;
    end
  end

  // Both counters stick at 255 rather than wrapping.
  always_comb begin
    rounds_d = rounds_q;
    ties_d   = ties_q;
    if (enterResult && (rounds_q != 8'hFF)) rounds_d = rounds_q + 8'd1;
    if (enterResult && playerWin_d && dealerWin_d && (ties_q != 8'hFF)) ties_d = ties_q + 8'd1;
  end

  assign rounds = rounds_q;
  assign ties   = ties_q;
`endif

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed self-checking bench for deal_sequencer and its banker_rule table.
// Define ROUND_COUNT_EN to also check the rounds/ties counters.
module tb_deal_sequencer;

  localparam int HOLD = 8;

  logic slow_clock;
  logic resetb;
  int   checkCount;
  int   errorCount;
  int   expRounds;
  int   expTies;

  logic [3:0] ruleDs;
  logic [3:0] rulePc;
  logic       ruleDraw;

  deal_sequencer_if bus ();

`ifdef ROUND_COUNT_EN
  logic [7:0] rounds;
  logic [7:0] ties;
`endif

  deal_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus)
`ifdef ROUND_COUNT_EN
    ,
    .rounds     (rounds),
    .ties       (ties)
`endif
  );

  banker_rule u_rule (
    .dscore (ruleDs),
    .pcard3 (rulePc),
    .draw   (ruleDraw)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3);
    bus.pscore = ps;
    bus.dscore = ds;
    bus.pcard3 = pc3;
  endtask

  task automatic waitCycle();
    @(posedge slow_clock);
    #1;
  endtask

  function automatic logic [5:0] strobes();
    return {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2,
            bus.load_dcard2, bus.load_pcard3, bus.load_dcard3};
  endfunction

  // Runs one round from IDLE; cycle 1 is the first cycle after go is sampled.
  task automatic playRound(input string tag, input logic [3:0] ps, input logic [3:0] ds,
                           input logic [3:0] pc3, input logic [3:0] dsAfterD3,
                           input int expP3, input int expD3, input int expLight,
                           input logic expPw, input logic expDw, input bit holdGo);
    int   p3At, d3At, p3Num, d3Num, overlapNum, lightAt, idleAt;
    logic p1Seen, lightsAtP1, pwSeen, dwSeen, pwIdle, dwIdle;
    p3At = 0; d3At = 0; p3Num = 0; d3Num = 0; overlapNum = 0; lightAt = 0; idleAt = 0;
    p1Seen = 1'b0; lightsAtP1 = 1'b1; pwSeen = 1'b0; dwSeen = 1'b0; pwIdle = 1'b0; dwIdle = 1'b0;
    applyStimulus(ps, ds, pc3);
    bus.go = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      waitCycle();
      if (!holdGo) bus.go = (cyc == 3);
      if ($countones(strobes()) > 1) overlapNum++;
      if (cyc == 1) begin
        p1Seen     = bus.load_pcard1;
        lightsAtP1 = bus.player_win_light | bus.dealer_win_light;
      end
      if (bus.load_pcard3) begin
        p3Num++;
        if (p3At == 0) p3At = cyc;
      end
      if (bus.load_dcard3) begin
        d3Num++;
        if (d3At == 0) d3At = cyc;
        bus.dscore = dsAfterD3;
      end
      if (lightAt == 0 && (bus.player_win_light || bus.dealer_win_light)) begin
        lightAt = cyc;
        pwSeen  = bus.player_win_light;
        dwSeen  = bus.dealer_win_light;
      end
      if (!bus.busy) begin
        idleAt = cyc;
        pwIdle = bus.player_win_light;
        dwIdle = bus.dealer_win_light;
        break;
      end
    end
    bus.go = holdGo;
    checkOutput({tag, " p1"}, p1Seen, 1);
    checkOutput({tag, " lightsClear"}, lightsAtP1, 0);
    checkOutput({tag, " p3At"}, p3At, expP3);
    checkOutput({tag, " p3Num"}, p3Num, (expP3 != 0) ? 1 : 0);
    checkOutput({tag, " d3At"}, d3At, expD3);
    checkOutput({tag, " d3Num"}, d3Num, (expD3 != 0) ? 1 : 0);
    checkOutput({tag, " overlap"}, overlapNum, 0);
    checkOutput({tag, " lightAt"}, lightAt, expLight);
    checkOutput({tag, " playerWin"}, pwSeen, expPw);
    checkOutput({tag, " dealerWin"}, dwSeen, expDw);
    checkOutput({tag, " idleAt"}, idleAt, expLight + HOLD);
    checkOutput({tag, " playerIdle"}, pwIdle, expPw);
    checkOutput({tag, " dealerIdle"}, dwIdle, expDw);
    expRounds++;
    if (expPw && expDw) expTies++;
    if (holdGo) begin
      waitCycle();
      checkOutput({tag, " autoRestart"}, bus.load_pcard1, 1);
      bus.go = 1'b0;
      for (int cyc = 0; cyc < 40 && bus.busy; cyc++) waitCycle();
      checkOutput({tag, " restartDone"}, bus.busy, 0);
      expRounds++;
      if (expPw && expDw) expTies++;
    end
  endtask

  function automatic logic expectedDraw(input int d, input int c);
    logic [9:0] mask;
    int         v;
    v = (c >= 10) ? 0 : c;
    case (d)
      0, 1, 2: mask = 10'h3FF;
      3:       mask = 10'h2FF;
      4:       mask = 10'h0FC;
      5:       mask = 10'h0F0;
      6:       mask = 10'h0C0;
      default: mask = 10'h000;
    endcase
    return mask[v];
  endfunction

  initial begin
    checkCount = 0;
    errorCount = 0;
    expRounds  = 0;
    expTies    = 0;
    ruleDs     = 4'd0;
    rulePc     = 4'd0;
    bus.go     = 1'b0;
    applyStimulus(4'd0, 4'd0, 4'd0);
    resetb = 1'b1;
    #1 resetb = 1'b0;
    repeat (2) waitCycle();
    checkOutput("reset strobes", strobes(), 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset lights", {bus.player_win_light, bus.dealer_win_light}, 0);
    @(negedge slow_clock);
    resetb = 1'b1;

    // Asynchronous reset while the sequencer is in S_P2.
    waitCycle();
    bus.go = 1'b1;
    repeat (3) waitCycle();
    checkOutput("midReset inP2", bus.load_pcard2, 1);
    resetb = 1'b0;
    #1;
    checkOutput("midReset strobes", strobes(), 0);
    checkOutput("midReset busy", bus.busy, 0);
    checkOutput("midReset lights", {bus.player_win_light, bus.dealer_win_light}, 0);
    @(negedge slow_clock);
    bus.go = 1'b0;
    resetb = 1'b1;
    waitCycle();
    checkOutput("midReset staysIdle", bus.busy, 0);

    playRound("natural",       4'd8,  4'd3, 4'd0,  4'd3, 0, 0, 6, 1'b1, 1'b0, 1'b0);
    playRound("playerDraw",    4'd4,  4'd6, 4'd5,  4'd6, 6, 0, 8, 1'b0, 1'b1, 1'b0);
    playRound("faceCard",      4'd2,  4'd3, 4'd12, 4'd3, 6, 8, 9, 1'b0, 1'b1, 1'b0);
    playRound("tie",           4'd7,  4'd5, 4'd0,  4'd7, 0, 6, 7, 1'b1, 1'b1, 1'b0);
    playRound("dealerNatural", 4'd5,  4'd9, 4'd0,  4'd9, 0, 0, 6, 1'b0, 1'b1, 1'b0);
    playRound("bothStand",     4'd6,  4'd7, 4'd0,  4'd7, 0, 0, 6, 1'b0, 1'b1, 1'b0);
    playRound("outOfRange",    4'd12, 4'd3, 4'd0,  4'd3, 0, 0, 6, 1'b1, 1'b0, 1'b0);
    playRound("bankerStand8",  4'd1,  4'd3, 4'd8,  4'd3, 6, 0, 8, 1'b0, 1'b1, 1'b0);
    playRound("bankerEdge",    4'd5,  4'd6, 4'd7,  4'd6, 6, 8, 9, 1'b0, 1'b1, 1'b0);
    playRound("restart",       4'd8,  4'd3, 4'd0,  4'd3, 0, 0, 6, 1'b1, 1'b0, 1'b1);

    for (int d = 0; d < 10; d++) begin
      for (int c = 0; c < 16; c++) begin
        ruleDs = d[3:0];
        rulePc = c[3:0];
        #1;
        checkOutput($sformatf("banker d%0d c%0d", d, c), ruleDraw, expectedDraw(d, c));
      end
    end
    ruleDs = 4'd3;
    rulePc = 4'd8;
    #1;
    checkOutput("banker d3 c8 stands", ruleDraw, 0);

`ifdef ROUND_COUNT_EN
    checkOutput("rounds count", rounds, expRounds);
    checkOutput("ties count", ties, expTies);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/deal_sequencer.md
Name: deal_sequencer

Overview:
Round controller for the baccarat datapath. It issues one-cycle load strobes to the six card registers in dealing order and applies the third-card rules using the running player/dealer scores. It drives the win lights and holds the result for a programmable time. It sits between the top level and the datapath/scorehand blocks, whose card registers feed the card7seg displays.

Parameters:
HOLD_CYCLES, 8, slow_clock cycles the result is held in S_RESULT before returning to S_IDLE (minimum 1).
HOLD_W, $clog2(HOLD_CYCLES+1), width of the hold counter.

Ports:
slow_clock  input  1  system clock; all state changes on rising edge.
resetb  input  1  asynchronous active-low reset.
go  input  1  level; a round starts on any edge where go=1 in S_IDLE.
pscore  input  4  player hand score 0-9 from scorehand; valid the cycle after a load strobe.
dscore  input  4  dealer hand score 0-9.
pcard3  input  4  raw player third card 0-15 from the datapath register.
load_pcard1, load_pcard2, load_pcard3  output  1 each  one-cycle player register strobes.
load_dcard1, load_dcard2, load_dcard3  output  1 each  one-cycle dealer register strobes.
player_win_light  output  1  player wins or ties.
dealer_win_light  output  1  dealer wins or ties; both lights high means a tie.
busy  output  1  high in every state except S_IDLE.

Behaviour:
- Reset: the block enters S_IDLE asynchronously. All outputs are 0 and the hold counter is 0.
- Strobes are Moore outputs of the current state. At most one strobe is high in any cycle.
- States and transitions:
  - S_IDLE -> S_P1 when go=1.
  - Fixed sequence: S_P1 -> S_D1 -> S_P2 -> S_D2 -> S_EVAL, one state per cycle.
- S_EVAL (scores now include all four cards):
  - Natural: pscore>=8 or dscore>=8 -> S_RESULT.
  - pscore<=5 -> S_P3.
  - Player stands (6-7): dscore<=5 -> S_D3, otherwise -> S_RESULT.
- S_P3 (asserts load_pcard3) -> S_BANK, where pcard3 is valid.
- S_BANK: v = (pcard3>=10) ? 0 : pcard3; pcard3 values 14-15 are treated as 0. Dealer draws (-> S_D3) when:
  - dscore<=2;
  - dscore==3 and v!=8;
  - dscore==4 and 2<=v<=7;
  - dscore==5 and 4<=v<=7;
  - dscore==6 and 6<=v<=7.
  - Otherwise -> S_RESULT.
- S_D3 (asserts load_dcard3) -> S_RESULT.
- S_RESULT:
  - Lights are registered on entry: player_win_light = (pscore>=dscore), dealer_win_light = (dscore>=pscore).
  - The hold counter counts up to HOLD_CYCLES-1, then -> S_IDLE.
  - Lights stay high through S_IDLE until the next S_P1, where both clear.
- Latency:
  - Shortest round (natural): go -> first strobe 1 cycle; go -> lights 6 cycles.
  - Longest round (P3 and D3): go -> lights 9 cycles.
- go is ignored while busy. Holding go high auto-restarts after each S_IDLE.
- Reset mid-round: immediate return to S_IDLE with all outputs 0. No partial strobe is emitted.
- Score inputs outside 0-9 are treated as >=8 (natural) in S_EVAL; this case is defensive only.

Optional Feature:
ROUND_COUNT_EN
- Defined:
  - Adds output rounds[7:0] and output ties[7:0], each reset to 0.
  - rounds increments on entry to S_RESULT; ties increments when both lights are set.
  - Both counters saturate at 255.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package baccarat_pkg holds:
  - enum state_t (S_IDLE, S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_BANK, S_D3, S_RESULT);
  - card constants (CARD_EMPTY=0, CARD_TEN=10);
  - function card_value(card), returning 0 for card>=10.
- Sub-module: banker_rule (combinational; inputs dscore and pcard3; output draw). It holds the third-card table and is testable exhaustively on its own.

Test Plan:
1. Reset mid-round: go=1, pulse resetb=0 during S_P2 -> all strobes and lights 0 immediately; busy=0.
2. Natural: scores after S_D2 are pscore=8, dscore=3 -> no load_pcard3/load_dcard3; player_win_light=1, dealer_win_light=0 6 cycles after go.
3. Player draws, dealer stands: pscore=4, dscore=6, pcard3=5 -> load_pcard3 pulses once, no load_dcard3; lights reflect the final scores.
4. Dealer draws on face card: pscore=2, dscore=3, pcard3=12 (v=0) -> load_pcard3 then load_dcard3 on the next-but-one cycle.
5. Player stands, dealer draws: pscore=7, dscore=5 -> load_dcard3 directly after S_EVAL. With final scores 7/7, both lights are 1 (tie).
6. Exhaustive banker_rule sweep: dscore 0-9 x pcard3 0-15 against the table, including dscore=3/pcard3=8 -> no draw. With ROUND_COUNT_EN defined, rounds=5 after five rounds.
